tmds_pattern_checker: RTL
=========================

# tmds_pattern_checker

Receive-side counterpart to the compliance pattern generator. Takes 10-bit TMDS symbols recovered by the deserializer, self-synchronises a local copy of the compliance PRBS, and reports lock status plus word-error statistics. It sits after the symbol deserializer in hardware-loopback and board-to-board link tests, and its counters are read over the debug register bus.

## Interface
- LOCK_COUNT, 16: consecutive matching words required to declare lock (≥1).
- UNLOCK_ERRS, 4: consecutive mismatching words while locked that force re-hunt (≥1).
- ERR_W, 32: width of the saturating error and word counters.

Ports:
- clk_i  in  1  symbol clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- symbol_valid_i  in  1  symbol_i carries a new word this cycle.
- symbol_i  in  10  received TMDS symbol.
- clear_i  in  1  synchronous clear of counters; lock state is unaffected.
- locked_o  out  1  checker is in LOCKED.
- error_o  out  1  one-cycle pulse: mismatch detected while LOCKED.
- error_count_o  out  ERR_W  mismatching words counted while LOCKED, saturating.
- word_count_o  out  ERR_W  valid words checked while LOCKED, saturating.
- bit_error_count_o  out  ERR_W  mismatching bits, saturating; present only with the macro (see Configuration).

## Operation
- Pattern definition: each word satisfies W[n+1] = step10(W[n]). step10 applies the 1-bit shift s ← {s[8:0], s[9]^s[6]} (x^10+x^7+1) ten times. step10 is combinational and has no state.
- Only cycles with symbol_valid_i=1 are processed. All other cycles hold every state and counter.
- FSM states are HUNT, VERIFY and LOCKED. Reset state is HUNT.
- HUNT:
  - On a non-zero word, load seed = word, set match_cnt = 0, and go to VERIFY.
  - A zero word is ignored, because zero is the LFSR lock-up state.
- VERIFY:
  - expected = step10(seed).
  - If word == expected: seed ← word, match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED.
  - If word differs: if the word is non-zero, reseed from it and set match_cnt = 0, staying in VERIFY; if the word is zero, go to HUNT.
- LOCKED:
  - expected = step10(pred), where pred is the internally predicted previous word. pred ← expected on every valid word, whether or not it matched, so a single corrupted word cannot propagate.
  - Every word increments word_count.
  - On a mismatch: error_o pulses, error_count++, and bad_run++.
  - On a match: bad_run = 0.
  - When bad_run reaches UNLOCK_ERRS, go to HUNT and clear bad_run.
- On entry to LOCKED, pred = the last matched word.
- Counters saturate at all-ones and never wrap.
- clear_i zeroes all counters. If clear_i coincides with an increment, clear wins and the counter reads 0.
- Reset zeroes all counters and match_cnt, and sets locked_o=0, error_o=0. Reset mid-operation returns the block to HUNT on the next edge.

## Timing
- All outputs are registered.
- locked_o rises one clk_i after the edge that samples the LOCK_COUNT-th matching word. It falls one clk_i after the edge that samples the UNLOCK_ERRS-th consecutive bad word.
- error_o and the counter updates are visible one cycle after the offending word is sampled. error_o is high for exactly one cycle per bad word, so back-to-back bad words produce back-to-back pulses.
- Minimum time to lock from reset is LOCK_COUNT+1 valid words (one seed word plus LOCK_COUNT matches).
- There is no backpressure: a symbol is accepted every cycle that symbol_valid_i=1.

## Configuration
- Macro TMDS_PATTERN_CHECKER_BIT_ERRORS_EN.
- Defined:
  - bit_error_count_o exists.
  - While LOCKED, each valid word adds popcount(word ^ expected), a value from 0 to 10, to bit_error_count_o.
  - It saturates at all-ones and follows the same clear and reset rules as the other counters.
- Undefined: the port, the popcount logic and the register are all absent. All other behaviour is identical.

## Test plan
- Lock from seed: feed 0x001, 0x009, then continue the step10 sequence for 16 more words (LOCK_COUNT=16). locked_o must rise exactly one cycle after the 17th word, and error_count_o must stay 0.
- Single bit error: while locked, flip bit 0 of one word. Required: one error_o pulse, error_count_o=1, bit_error_count_o=1 if the macro is enabled, locked_o stays 1, and the following correct words produce no further errors.
- Unlock: while locked, feed 4 consecutive 0x3FF words (UNLOCK_ERRS=4). Required: error_count_o=4 and locked_o=0 one cycle after the 4th word. A correct stream must then re-lock after 17 words.
- Zero word and gaps:
  - Feed zeros in HUNT: the block must stay in HUNT with locked_o=0.
  - Interleave symbol_valid_i=0 cycles into a valid stream: lock timing must count valid words only.
- Saturation and clear (ERR_W=4):
  - 20 bad words while locked (UNLOCK_ERRS=31) must leave error_count_o at 15.
  - Asserting clear_i in the same cycle as a bad word must read 0 afterwards.
- Reset mid-VERIFY: assert rst_i after 8 matches. Required: locked_o=0, all counters 0, and lock again requires a fresh seed plus 16 matches.

Source files
------------

// File: rtl/tmds_pattern_checker.sv
// tmds_pattern_checker: self-synchronising TMDS compliance PRBS checker (option: TMDS_PATTERN_CHECKER_BIT_ERRORS_EN adds bit_error_count_o)
module tmds_pattern_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             symbol_valid_i,
  input  logic [9:0]       symbol_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             error_o,
  output logic [ERR_W-1:0] error_count_o,
`ifdef TMDS_PATTERN_CHECKER_BIT_ERRORS_EN
  output logic [ERR_W-1:0] bit_error_count_o,
`endif
  output logic [ERR_W-1:0] word_count_o
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t state_q, state_n;
  logic [9:0] ref_q, ref_n, expected;
  logic [MW-1:0] match_q, match_n;
  logic [BW-1:0] bad_q, bad_n;
  logic mismatch, in_lock, err_n;
  function automatic logic [9:0] step10(input logic [9:0] s);
    logic [9:0] t;
    t = s;
    for (int i = 0; i < 10; i++) t = {t[8:0], t[9] ^ t[6]};
    return t;
  endfunction
  // ref_q holds the seed in VERIFY and the predicted previous word in LOCKED
  always_comb begin
    expected = step10(ref_q);
    mismatch = symbol_i != expected;
    in_lock  = symbol_valid_i && state_q == LOCKED;
    err_n    = in_lock && mismatch;
    state_n  = state_q;
    ref_n    = ref_q;
    match_n  = match_q;
    bad_n    = bad_q;
    if (symbol_valid_i)
      case (state_q)
        HUNT: if (symbol_i != '0) begin
          ref_n   = symbol_i;
          match_n = '0;
          state_n = VERIFY;
        end
        VERIFY: if (!mismatch) begin
          ref_n   = symbol_i;
          match_n = match_q + 1'b1;
          if (match_n == MW'(LOCK_COUNT)) begin
            state_n = LOCKED;
            bad_n   = '0;
          end
        end else if (symbol_i != '0) begin
          ref_n   = symbol_i;
          match_n = '0;
        end else state_n = HUNT;
        LOCKED: begin
          ref_n = expected;
          bad_n = mismatch ? bad_q + 1'b1 : '0;
          if (bad_n == BW'(UNLOCK_ERRS)) begin
            state_n = HUNT;
            bad_n   = '0;
          end
        end
        default: state_n = HUNT;
      endcase
  end
  // state register
  always_ff @(posedge clk_i)
    state_q <= rst_i ? HUNT : state_n;
  // tracking registers, status flags and saturating counters; clear beats increment
  always_ff @(posedge clk_i)
    if (rst_i) begin
      ref_q         <= '0;
      match_q       <= '0;
      bad_q         <= '0;
      locked_o      <= 1'b0;
      error_o       <= 1'b0;
      error_count_o <= '0;
      word_count_o  <= '0;
    end else begin
      ref_q         <= ref_n;
      match_q       <= match_n;
      bad_q         <= bad_n;
      locked_o      <= state_n == LOCKED;
      error_o       <= err_n;
      error_count_o <= clear_i ? '0 : (err_n && ~&error_count_o) ? error_count_o + 1'b1 : error_count_o;
      word_count_o  <= clear_i ? '0 : (in_lock && ~&word_count_o) ? word_count_o + 1'b1 : word_count_o;
    end
`ifdef TMDS_PATTERN_CHECKER_BIT_ERRORS_EN
  logic [3:0] pop;
  logic [ERR_W:0] bit_sum;
  // per-word count of differing bits added to a saturating total
  always_comb begin
    pop = '0;
    for (int i = 0; i < 10; i++) pop = pop + {3'b0, symbol_i[i] ^ expected[i]};
    bit_sum = {1'b0, bit_error_count_o} + (ERR_W + 1)'(pop);
  end
  // bit error accumulator
  always_ff @(posedge clk_i)
    if (rst_i || clear_i) bit_error_count_o <= '0;
    else if (in_lock) bit_error_count_o <= bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
`endif
endmodule
